harness_cmd_decoder: RTL and testbench
======================================

Name: harness_cmd_decoder

Overview:
- Synthesizable command front-end for a design under test (DUT).
- Consumes the host byte-command stream used by the simulation harness: 104 read outputs, 105 quit, 106 assert DUT reset, 107 release DUT reset, 108 step one cycle, 109 load inputs.
- Drives the DUT's packed input vector, reset and step enable, and serializes the DUT's packed output vector back to the host as little-endian bytes.
- Sits between a host byte link (UART/FIFO) and the DUT wrapper.

Parameters:
- INPUT_BYTES, 4: bytes in one input load; dut_data_in width = INPUT_BYTES*8.
- OUTPUT_WORDS, 1: 32-bit words returned per read; dut_data_out width = OUTPUT_WORDS*32.

Ports:
- clk  in  1  single clock; everything below is in this domain.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  command/data byte from host.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  block accepts in_byte this cycle.
- out_byte  out  8  response byte to host.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  host accepts out_byte.
- dut_data_in  out  INPUT_BYTES*8  packed DUT inputs.
- dut_rst  out  1  reset to DUT.
- dut_step  out  1  one-cycle clock-enable pulse to DUT.
- dut_data_out  in  OUTPUT_WORDS*32  packed DUT outputs.
- done  out  1  quit command received.
- error  out  1  unknown command received.
- err_code  out  8  offending byte.

Behaviour:
- Handshakes: a byte transfers on in_valid&&in_ready. Out transfers on out_valid&&out_ready. While out_valid=1 and out_ready=0, out_byte is held stable.
- Reset values: in_ready=1, out_valid=0, out_byte=0, dut_data_in=0, dut_rst=1, dut_step=0, done=0, error=0, err_code=0. The shadow register and counters are cleared; state=IDLE.
- States:
  - IDLE: in_ready=1. On an accepted byte, transition is registered and the effect is visible in cycle N+1.
    - 104: capture dut_data_out into the send shift register at the accepting edge. Go to SEND with counter=OUTPUT_WORDS*4-1.
    - 105: done<=1; go to HALT.
    - 106: dut_rst<=1. 107: dut_rst<=0. Stay in IDLE.
    - 108: dut_step=1 for exactly cycle N+1. Back-to-back 108 bytes give back-to-back pulses.
    - 109: go to LOAD with counter=INPUT_BYTES-1.
    - Any other value: error<=1, err_code<=byte; go to HALT.
  - LOAD: in_ready=1. Each accepted byte is shifted into the shadow as shadow={byte, shadow[top:8]}, so the first byte lands in bits [7:0].
    - On the final byte (counter=0), dut_data_in<=new shadow atomically and go to IDLE.
    - dut_data_in never shows a partial load. Load bytes are never interpreted as commands.
  - SEND: in_ready=0, out_valid=1, out_byte=shift[7:0]. Byte order is word 0 first, each word LSB first (word w byte b = bits [32w+8b+7 : 32w+8b]).
    - On each out handshake, shift right by 8 and decrement the counter.
    - On the handshake of the last byte, go to IDLE. out_valid=0 and in_ready=1 in the next cycle.
  - HALT: in_ready=0, out_valid=0. done/error stay held; leave only via rst.
- dut_step is 0 in every cycle not directly following an accepted 108.
- dut_rst and dut_data_in persist across all states until changed by a command or by rst.
- Counter widths are $clog2 of max(INPUT_BYTES, OUTPUT_WORDS*4)+1. No wrap occurs because each count terminates at 0.
- Simultaneous events:
  - rst wins over any handshake in the same cycle.
  - In SEND the block never accepts input, so in/out transfers cannot collide.
- Reset mid-operation:
  - Mid-LOAD: the partial shadow is discarded and dut_data_in=0.
  - Mid-SEND: remaining bytes are dropped and out_valid=0 next cycle.
  - In HALT: done/error clear.

Test Plan:
- After rst, send 107, then 108 three times back-to-back with in_valid held → dut_rst falls the cycle after 107; dut_step high for exactly 3 consecutive cycles, then 0.
- INPUT_BYTES=4: send 109, 0x11, 0x22, 0x33, 0x44 → dut_data_in stays 0 during the load, then becomes 0x44332211 the cycle after 0x44. Send 109, 0xAA, then assert rst → dut_data_in=0, state IDLE.
- OUTPUT_WORDS=2, dut_data_out=0xCAFEBABE_12345678, send 104 while out_ready toggles 1,0,1,… → out_byte sequence 78 56 34 12 BE BA FE CA, each held while out_ready=0; in_ready=0 throughout SEND.
- Change dut_data_out in the cycle after 104 is accepted → returned bytes reflect the value sampled at the accepting edge.
- Send 0x41 → error=1, err_code=0x41, in_ready=0. Further bytes are ignored until rst, after which all outputs take their reset values.
- Send 105 → done=1, in_ready=0 permanently. A later 108 produces no dut_step.

Source files
------------

// File: rtl/harness_cmd_decoder_if.sv
// Host byte link between the harness host and the command decoder.
// The host owns in_byte/in_valid and out_ready; the decoder owns the rest.
interface harness_cmd_decoder_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (output in_byte, in_valid, out_ready,
                  input  in_ready, out_byte, out_valid);
  modport slave  (input  in_byte, in_valid, out_ready,
                  output in_ready, out_byte, out_valid);
endinterface

// File: rtl/harness_cmd_decoder.sv
// Byte-command front-end for a DUT: loads packed inputs, drives reset and
// single-cycle step pulses, and streams packed outputs back LSB first.
module harness_cmd_decoder #(
  parameter int INPUT_BYTES  = 4,
  parameter int OUTPUT_WORDS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  harness_cmd_decoder_if.slave         host,
  output logic [INPUT_BYTES*8-1:0]     dut_data_in,
  output logic                         dut_rst,
  output logic                         dut_step,
  input  logic [OUTPUT_WORDS*32-1:0]   dut_data_out,
  output logic                         done,
  output logic                         error,
  output logic [7:0]                   err_code
);

  localparam int IW     = INPUT_BYTES * 8;
  localparam int OW     = OUTPUT_WORDS * 32;
  localparam int OBYTES = OUTPUT_WORDS * 4;
  localparam int MAXC   = (INPUT_BYTES > OBYTES) ? INPUT_BYTES : OBYTES;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [7:0] CMD_READ    = 8'd104;
  localparam logic [7:0] CMD_QUIT    = 8'd105;
  localparam logic [7:0] CMD_RST_ON  = 8'd106;
  localparam logic [7:0] CMD_RST_OFF = 8'd107;
  localparam logic [7:0] CMD_STEP    = 8'd108;
  localparam logic [7:0] CMD_LOAD    = 8'd109;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HALT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   shadow;
  logic [IW-1:0]   shadow_nxt;
  logic [IW+7:0]   shadow_cat;
  logic [OW-1:0]   shift;
  logic [CW-1:0]   cnt;
  logic            in_rdy, out_vld, in_acc, out_acc;

  // Handshake strobes depend only on state, so no path runs from valid to ready.
  assign in_rdy  = (state == IDLE) || (state == LOAD);
  assign out_vld = (state == SEND);
  assign in_acc  = host.in_valid && in_rdy;
  assign out_acc = out_vld && host.out_ready;

  assign host.in_ready  = in_rdy;
  assign host.out_valid = out_vld;
  assign host.out_byte  = out_vld ? shift[7:0] : 8'd0;

  // New byte enters at the top; written via a concat so INPUT_BYTES=1 works.
  assign shadow_cat = {host.in_byte, shadow};
  assign shadow_nxt = shadow_cat[IW+7:8];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_acc) begin
        case (host.in_byte)
          CMD_READ:                       state_nxt = SEND;
          CMD_LOAD:                       state_nxt = LOAD;
          CMD_RST_ON, CMD_RST_OFF,
          CMD_STEP:                       state_nxt = IDLE;
          default:                        state_nxt = HALT; // quit or unknown
        endcase
      end
      LOAD:    if (in_acc && cnt == '0)  state_nxt = IDLE;
      SEND:    if (out_acc && cnt == '0) state_nxt = IDLE;
      default:                           state_nxt = HALT;
    endcase
  end

  // Datapath: DUT controls, load shadow, send shifter and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      shift       <= '0;
      cnt         <= '0;
      dut_data_in <= '0;
      dut_rst     <= 1'b1;
      dut_step    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 8'd0;
    end else begin
      dut_step <= 1'b0;
      case (state)
        IDLE: if (in_acc) begin
          case (host.in_byte)
            CMD_READ: begin
              shift <= dut_data_out;
              cnt   <= CW'(OBYTES - 1);
            end
            CMD_QUIT:    done     <= 1'b1;
            CMD_RST_ON:  dut_rst  <= 1'b1;
            CMD_RST_OFF: dut_rst  <= 1'b0;
            CMD_STEP:    dut_step <= 1'b1;
            CMD_LOAD:    cnt      <= CW'(INPUT_BYTES - 1);
            default: begin
              error    <= 1'b1;
              err_code <= host.in_byte;
            end
          endcase
        end
        LOAD: if (in_acc) begin
          shadow <= shadow_nxt;
          // Publish only the complete vector so the DUT never sees a partial load.
          if (cnt == '0) dut_data_in <= shadow_nxt;
          else           cnt         <= cnt - 1'b1;
        end
        SEND: if (out_acc) begin
          shift <= shift >> 8;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_harness_cmd_decoder.sv
// Directed + randomized bench for harness_cmd_decoder with a host-level model.
module tb_harness_cmd_decoder;
  localparam int IB  = 4;
  localparam int OWD = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [IB*8-1:0]    dut_data_in;
  logic               dut_rst, dut_step;
  logic [OWD*32-1:0]  dut_data_out;
  logic               done, error;
  logic [7:0]         err_code;

  harness_cmd_decoder_if bus();

  harness_cmd_decoder #(.INPUT_BYTES(IB), .OUTPUT_WORDS(OWD)) u_dut (
    .clk(clk), .rst(rst), .host(bus),
    .dut_data_in(dut_data_in), .dut_rst(dut_rst), .dut_step(dut_step),
    .dut_data_out(dut_data_out), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Host-visible model state.
  logic [IB*8-1:0] m_din;
  logic            m_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_persist(input string tag);
    chk({tag, "_rst"}, dut_rst, m_rst);
    chk({tag, "_din"}, dut_data_in, m_din);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_byte", bus.out_byte, 0);
    chk("rst_din", dut_data_in, 0);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_step", dut_step, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    rst   = 1'b0;
    m_din = '0;
    m_rst = 1'b1;
  endtask

  // One accepted byte; returns at the negedge of cycle N+1.
  task automatic send(input logic [7:0] b);
    chk("send_in_ready", bus.in_ready, 1);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'($urandom);
  endtask

  task automatic cmd_dut_rst(input logic on);
    send(on ? 8'd106 : 8'd107);
    m_rst = on;
    chk("cmd_dut_rst", dut_rst, m_rst);
  endtask

  task automatic cmd_step();
    send(8'd108);
    chk("step_pulse", dut_step, 1);
    @(negedge clk);
    chk("step_after", dut_step, 0);
  endtask

  task automatic cmd_load(input logic [IB*8-1:0] v);
    send(8'd109);
    for (int i = 0; i < IB; i++) begin
      chk("load_no_partial", dut_data_in, m_din);
      send(v[8*i +: 8]);
    end
    m_din = v;
    chk("load_final", dut_data_in, m_din);
  endtask

  // mode 0: out_ready toggles 1,0,1..; 1: random; 2: always ready
  task automatic cmd_read(input int mode);
    logic [OWD*32-1:0] cap;
    logic [7:0]        exp_b;
    int  k = 0, budget = 0;
    bit  tog = 1'b1, r;
    cap = dut_data_out;
    send(8'd104);
    dut_data_out = {$urandom, $urandom};  // must not leak into this read
    while (k < OWD*4 && budget < 200) begin
      exp_b = 8'(cap >> (8*k));
      chk("read_out_valid", bus.out_valid, 1);
      chk("read_in_ready", bus.in_ready, 0);
      chk("read_out_byte", bus.out_byte, exp_b);
      chk("read_no_step", dut_step, 0);
      r = (mode == 0) ? tog : (mode == 1) ? 1'($urandom) : 1'b1;
      tog = ~tog;
      bus.out_ready = r;
      bus.in_valid  = 1'($urandom);   // must be ignored during SEND
      bus.in_byte   = 8'd108;
      @(negedge clk);
      if (r) k++;
      budget++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (budget >= 200) begin
      checks++; errors++;
      $error("FAIL read_timeout observed=%0d expected=%0d", k, OWD*4);
    end
    chk("read_end_out_valid", bus.out_valid, 0);
    chk("read_end_in_ready", bus.in_ready, 1);
    chk("read_end_step", dut_step, 0);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'd0;
    bus.out_ready = 1'b0;
    dut_data_out  = '0;
    m_din = '0;
    m_rst = 1'b1;
    do_reset();

    // Release reset, then three back-to-back step commands.
    cmd_dut_rst(1'b0);
    bus.in_byte  = 8'd108;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_step", dut_step, 1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_step_end", dut_step, 0);

    // Directed load.
    cmd_load(32'h44332211);
    chk_persist("after_load");

    // Directed read with toggling out_ready.
    dut_data_out = 64'hCAFEBABE_12345678;
    cmd_read(0);
    chk_persist("after_read");

    // Randomized command mix.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin dut_data_out = {$urandom, $urandom}; cmd_read(int'($urandom_range(0, 2))); end
        1: cmd_dut_rst(1'($urandom));
        2: cmd_step();
        3: cmd_load($urandom);
        default: begin @(negedge clk); chk("idle_step", dut_step, 0); end
      endcase
      chk_persist("rand");
    end

    // Reset in the middle of a load.
    cmd_load(32'h55667788);
    send(8'd109);
    send(8'hAA);
    chk("midload_din_held", dut_data_in, 32'h55667788);
    do_reset();
    cmd_step();   // back in IDLE: 108 is a command again

    // Reset in the middle of a send.
    dut_data_out = 64'h0123456789ABCDEF;
    send(8'd104);
    chk("midsend_byte0", bus.out_byte, 8'hEF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("midsend_byte1", bus.out_byte, 8'hCD);
    do_reset();

    // Unknown command halts with the byte reported.
    send(8'h41);
    chk("err_flag", error, 1);
    chk("err_code", err_code, 8'h41);
    chk("err_in_ready", bus.in_ready, 0);
    chk("err_done", done, 0);
    bus.in_byte  = 8'd108;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_ignored_step", dut_step, 0);
      chk("err_held", error, 1);
    end
    bus.in_valid = 1'b0;
    do_reset();

    // Random unknown byte (outside 104..109).
    do b = 8'($urandom); while (b >= 8'd104 && b <= 8'd109);
    send(b);
    chk("err_rand_flag", error, 1);
    chk("err_rand_code", err_code, b);
    do_reset();

    // Quit.
    send(8'd105);
    chk("quit_done", done, 1);
    chk("quit_in_ready", bus.in_ready, 0);
    chk("quit_error", error, 0);
    bus.in_byte  = 8'd108;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("quit_no_step", dut_step, 0);
      chk("quit_held", done, 1);
    end
    bus.in_valid = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
